// File: rtl/ibex_register_file_wr_ctrl.sv
// Write-port controller for a RAM-based register file: zero-fills x1.. after reset
// or on request, then arbitrates the single write port between core and aux.
module ibex_register_file_wr_ctrl #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned StarveThresh = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_req_i,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 aux_req_i,
  input  logic [4:0]           aux_waddr_i,
  input  logic [DataWidth-1:0] aux_wdata_i,
  output logic                 aux_gnt_o,
  output logic                 aux_starved_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 busy_o,
  output logic                 core_err_o
);
  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam logic [4:0]  LastAddr = 5'(NumWords - 1);
  localparam logic [4:0]  AddrMask = RV32E ? 5'h0f : 5'h1f;
  localparam logic [7:0]  Thresh   = 8'(StarveThresh);

  typedef enum logic [1:0] {ST_RST, ST_INIT, ST_IDLE} state_e;

  state_e               r_state, w_state_nxt;
  logic [4:0]           r_cnt, w_cnt_nxt;
  logic [7:0]           r_scnt, w_scnt_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_starved;
  logic                 w_we, w_gnt, w_busy;
  logic [4:0]           w_waddr;
  logic [DataWidth-1:0] w_wdata;
  logic [4:0]           w_core_addr, w_aux_addr;

  // Bit 4 is meaningless for a 16-entry file, so fold it away before the x0 test.
  assign w_core_addr = core_waddr_i & AddrMask;
  assign w_aux_addr  = aux_waddr_i & AddrMask;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_we        = 1'b0;
    w_waddr     = 5'd0;
    w_wdata     = '0;
    w_gnt       = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_RST: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = 5'd1;
        if (core_we_i) w_err_nxt = 1'b1;
      end
      ST_INIT: begin
        w_we      = 1'b1;
        w_waddr   = r_cnt;
        w_cnt_nxt = r_cnt + 5'd1;
        if (core_we_i) w_err_nxt = 1'b1;
        if (r_cnt == LastAddr) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        w_busy = 1'b0;
        if (core_we_i) begin
          if (w_core_addr != 5'd0) begin
            w_we    = 1'b1;
            w_waddr = w_core_addr;
            w_wdata = core_wdata_i;
          end
        end else if (aux_req_i) begin
          // x0 requests are granted so the requester retires them, but never written.
          w_gnt = 1'b1;
          if (w_aux_addr != 5'd0) begin
            w_we    = 1'b1;
            w_waddr = w_aux_addr;
            w_wdata = aux_wdata_i;
          end
        end
        if (init_req_i) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = 5'd1;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    w_scnt_nxt = 8'd0;
    if (aux_req_i && !w_gnt) w_scnt_nxt = (r_scnt == 8'hff) ? r_scnt : r_scnt + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_RST;
      r_cnt     <= 5'd1;
      r_scnt    <= 8'd0;
      r_err     <= 1'b0;
      r_starved <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_scnt    <= w_scnt_nxt;
      r_err     <= w_err_nxt;
      r_starved <= (w_scnt_nxt >= Thresh);
    end
  end

  assign rf_we_o       = w_we;
  assign rf_waddr_o    = w_waddr;
  assign rf_wdata_o    = w_wdata;
  assign aux_gnt_o     = w_gnt;
  assign busy_o        = w_busy;
  assign core_err_o    = r_err;
  assign aux_starved_o = r_starved;
endmodule

// File: tb/tb_ibex_register_file_wr_ctrl.sv
// Bench: RV32I and RV32E instances share stimulus; a clear-queue model checks every cycle.
module tb_ibex_register_file_wr_ctrl;
  localparam int THR = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0, core_we = 1'b0, aux_req = 1'b0;
  logic [4:0]  core_waddr = '0, aux_waddr = '0;
  logic [31:0] core_wdata = '0, aux_wdata = '0;

  logic        o0_gnt, o0_starved, o0_we, o0_busy, o0_err;
  logic [4:0]  o0_waddr;
  logic [31:0] o0_wdata;
  logic        o1_gnt, o1_starved, o1_we, o1_busy, o1_err;
  logic [4:0]  o1_waddr;
  logic [31:0] o1_wdata;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  ibex_register_file_wr_ctrl #(.RV32E(1'b0), .DataWidth(32), .StarveThresh(THR)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .aux_req_i(aux_req), .aux_waddr_i(aux_waddr), .aux_wdata_i(aux_wdata),
    .aux_gnt_o(o0_gnt), .aux_starved_o(o0_starved), .rf_we_o(o0_we),
    .rf_waddr_o(o0_waddr), .rf_wdata_o(o0_wdata), .busy_o(o0_busy), .core_err_o(o0_err));

  ibex_register_file_wr_ctrl #(.RV32E(1'b1), .DataWidth(32), .StarveThresh(THR)) u_dut_e (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req),
    .core_we_i(core_we), .core_waddr_i(core_waddr), .core_wdata_i(core_wdata),
    .aux_req_i(aux_req), .aux_waddr_i(aux_waddr), .aux_wdata_i(aux_wdata),
    .aux_gnt_o(o1_gnt), .aux_starved_o(o1_starved), .rf_we_o(o1_we),
    .rf_waddr_o(o1_waddr), .rf_wdata_o(o1_wdata), .busy_o(o1_busy), .core_err_o(o1_err));

  // Register file fed by the RV32I instance; preloaded with garbage while pre=1.
  logic        pre = 1'b1;
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : (32'hA5A5_0000 | 32'(i));
    end else if (o0_we) begin
      rf[o0_waddr] <= o0_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a clear is a run of zero writes to x(nw-clr) while clr>0; the x0
  // slot stands for the reset cycle. Otherwise fixed-priority core/aux.
  int   clr0 = 32, clr1 = 16, w0 = 0, w1 = 0;
  logic err0 = 1'b0, err1 = 1'b0, st0 = 1'b0, st1 = 1'b0;

  function automatic logic [41:0] expv(input int nw, input int clr, input logic err, input logic st);
    logic we, g; logic [4:0] a; logic [31:0] d; int addr;
    we = 1'b0; g = 1'b0; a = '0; d = '0;
    if (clr > 0) begin
      addr = nw - clr;
      if (addr != 0) begin we = 1'b1; a = 5'(addr); end
    end else if (core_we) begin
      addr = int'(core_waddr) % nw;
      if (addr != 0) begin we = 1'b1; a = 5'(addr); d = core_wdata; end
    end else if (aux_req) begin
      g = 1'b1;
      addr = int'(aux_waddr) % nw;
      if (addr != 0) begin we = 1'b1; a = 5'(addr); d = aux_wdata; end
    end
    return {we, a, d, g, (clr > 0), err, st};
  endfunction

  task automatic upd(input int nw, inout int clr, inout logic err, inout int w, inout logic st);
    logic [41:0] e;
    e = expv(nw, clr, err, st);
    if (clr > 0 && core_we) err = 1'b1;
    else if (clr == 0 && init_req) err = 1'b0;
    if (aux_req && !e[3]) w = (w < 255) ? w + 1 : 255;
    else w = 0;
    st = (w >= THR);
    if (clr > 0) clr = clr - 1;
    else if (init_req) clr = nw - 1;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      clr0 = 32; clr1 = 16; err0 = 0; err1 = 0; w0 = 0; w1 = 0; st0 = 0; st1 = 0;
    end
    chk("port_rv32i", {22'd0, o0_we, o0_waddr, o0_wdata, o0_gnt, o0_busy, o0_err, o0_starved},
        {22'd0, expv(32, clr0, err0, st0)});
    chk("port_rv32e", {22'd0, o1_we, o1_waddr, o1_wdata, o1_gnt, o1_busy, o1_err, o1_starved},
        {22'd0, expv(16, clr1, err1, st1)});
    if (rst_n) begin
      upd(32, clr0, err0, w0, st0);
      upd(16, clr1, err1, w1, st1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    core_we = 0; aux_req = 0; init_req = 0;
    core_waddr = '0; aux_waddr = '0; core_wdata = '0; aux_wdata = '0;
  endtask

  // Counts busy negedges starting at the current one (caller sits on a negedge).
  task automatic count_busy(output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 100; i++) begin
      if (!o0_busy) break;
      n0++;
      if (o1_busy) n1++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic cwe; logic [4:0] ca; logic [31:0] cd;
    logic areq; logic [4:0] aa; logic [31:0] ad;
    logic ewe; logic [4:0] ea; logic [31:0] ed; logic eg;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int n0, n1;
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd6, 32'h1,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6, 32'h1,  1'b1, 5'd6,  32'h1,        1'b1};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 5'd0,  32'h0,        1'b1};
    tbl[3] = '{1'b1, 5'd0,  32'h77,       1'b1, 5'd7, 32'h9,  1'b0, 5'd0,  32'h0,        1'b0};
    tbl[4] = '{1'b0, 5'd3,  32'h3,        1'b0, 5'd4, 32'h4,  1'b0, 5'd0,  32'h0,        1'b0};
    tbl[5] = '{1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0, 32'h0,  1'b1, 5'd31, 32'h12345678, 1'b0};
    tbl[6] = '{1'b0, 5'd17, 32'hCAFE,     1'b1, 5'd17,32'hBEEF,1'b1, 5'd17, 32'hBEEF,     1'b1};

    // Reset release over a garbage-filled file.
    repeat (3) @(posedge clk);
    #1; pre = 0; rst_n = 1;
    @(negedge clk);
    count_busy(n0, n1);
    chk("clear_len_rv32i", 64'(n0), 64'd32);
    chk("clear_len_rv32e", 64'(n1), 64'd16);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d_zero", i), {32'd0, rf[i]}, 64'd0);

    // Arbitration table in IDLE.
    step();
    for (int i = 0; i < 7; i++) begin
      core_we = tbl[i].cwe; core_waddr = tbl[i].ca; core_wdata = tbl[i].cd;
      aux_req = tbl[i].areq; aux_waddr = tbl[i].aa; aux_wdata = tbl[i].ad;
      @(negedge clk);
      chk($sformatf("arb_vec%0d", i), {25'd0, o0_we, o0_waddr, o0_wdata, o0_gnt},
          {25'd0, tbl[i].ewe, tbl[i].ea, tbl[i].ed, tbl[i].eg});
      step();
    end
    idle_inputs();
    step();

    // Aux starvation behind 10 back-to-back core writes.
    for (int i = 1; i <= 10; i++) begin
      core_we = 1; core_waddr = 5'd3; core_wdata = 32'(i);
      aux_req = 1; aux_waddr = 5'd9; aux_wdata = 32'hA0A0;
      @(negedge clk);
      chk($sformatf("starve_c%0d", i), {63'd0, o0_starved}, {63'd0, (i >= 9)});
      step();
    end
    core_we = 0;
    @(negedge clk);
    chk("starve_grant", {62'd0, o0_gnt, o0_starved}, 64'd3);
    step();
    aux_req = 0;
    @(negedge clk);
    chk("starve_clear", {63'd0, o0_starved}, 64'd0);
    step();

    // Core write during clear at cnt=7 is dropped and latches the error.
    rst_n = 0; step(); rst_n = 1;
    repeat (7) step();
    core_we = 1; core_waddr = 5'd9; core_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("err_drop", {26'd0, o0_we, o0_waddr, o0_wdata}, {26'd0, 1'b1, 5'd7, 32'd0});
    step();
    core_we = 0;
    @(negedge clk);
    chk("err_set", {63'd0, o0_err}, 64'd1);
    count_busy(n0, n1);
    chk("err_reach_idle", {63'd0, o0_busy}, 64'd0);
    chk("err_sticky", {63'd0, o0_err}, 64'd1);
    step();
    init_req = 1;
    step();
    init_req = 0;
    @(negedge clk);
    chk("reinit_state", {57'd0, o0_err, o0_busy, o0_waddr}, {57'd0, 1'b0, 1'b1, 5'd1});
    count_busy(n0, n1);
    chk("reinit_len_rv32i", 64'(n0), 64'd31);
    chk("reinit_len_rv32e", 64'(n1), 64'd15);

    // Reset mid-clear at cnt=10.
    step();
    rst_n = 0; step(); rst_n = 1;
    repeat (10) step();
    @(negedge clk);
    chk("mid_cnt10", {58'd0, o0_we, o0_waddr}, {58'd0, 1'b1, 5'd10});
    #2 rst_n = 0;
    #1 chk("mid_rst_now", {57'd0, o0_we, o0_busy, o0_waddr}, {57'd0, 1'b0, 1'b1, 5'd0});
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    step();
    @(negedge clk);
    chk("mid_restart_x1", {58'd0, o0_we, o0_waddr}, {58'd0, 1'b1, 5'd1});
    count_busy(n0, n1);
    chk("mid_reach_idle", {63'd0, o0_busy}, 64'd0);

    // Random traffic against the model.
    step();
    for (int i = 0; i < 600; i++) begin
      core_we    = ($urandom % 2) == 0;
      core_waddr = 5'($urandom);
      core_wdata = $urandom;
      aux_req    = ($urandom % 3) != 0;
      aux_waddr  = 5'($urandom);
      aux_wdata  = $urandom;
      init_req   = ($urandom % 40) == 0;
      step();
    end
    idle_inputs();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
